pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined integer add/subtract unit; the multi-cycle successor to the single-cycle 64-bit adder.
- Splits the WIDTH-bit carry chain into STAGES equal chunks, one chunk per pipeline stage, to shorten the critical path.
- Produces LEGv8-style N/Z/C/V flags with the result.
- Sits in the EX stage; valid/ready handshakes on both sides let the pipeline stall it.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry-chain chunks; 1 <= STAGES <= WIDTH. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and sub are valid this cycle.
- in_ready  output  1  unit accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a-b (a + ~b + 1).
- out_valid  output  1  out and flags hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result, modulo 2^WIDTH.
- flag_n  output  1  out[WIDTH-1].
- flag_z  output  1  out == 0.
- flag_c  output  1  carry out of the MSB. For subtraction this is NOT-borrow.
- flag_v  output  1  signed overflow.
- busy  output  1  at least one operation is in flight or held at the output.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All stage valid bits, out, and all flags go to 0; out_valid=0, busy=0.
  - Any in-flight operations are discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational).
- An operation is accepted when in_valid && in_ready.
- When adv=0, every stage register holds its value.
  - out and all flags remain stable while out_valid=1 && out_ready=0.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of a and chunk k of b' (b' = sub ? ~b : b) plus the carry from stage k-1.
  - Stage 0 carry-in is sub.
  - Unprocessed upper operand chunks travel with the operation (skewed pipeline).
  - Lower result chunks already produced travel forward with it.
- Latency: result appears on out/out_valid exactly STAGES cycles after acceptance, given adv=1 throughout. Each stall cycle adds one cycle.
- Throughput: one operation per cycle when out_ready is held at 1.
- Bubbles: an invalid slot advances like a valid one. out_valid follows the valid bit of the last stage.
- Flags are computed at the last stage:
  - N = result MSB.
  - Z = all result bits 0.
  - C = carry out of the top chunk.
  - V = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]).
- Simultaneous out_ready and in_valid while full: the output is consumed and a new op is accepted in the same cycle; no loss, no duplication.
- STAGES=1: single registered stage, latency 1, same handshake.
- busy = OR of all stage valid bits.
- Arithmetic is unsigned modulo 2^WIDTH. No saturation.

Test Plan:
- Add, WIDTH=64, STAGES=4, a=0x1234567890ABCDEF, b=0xFEDCBA0987654321, sub=0, out_ready=1 -> after exactly 4 cycles: out=0x1111108218111110, C=1, N=0, Z=0, V=0, out_valid high for one cycle.
- Subtract a=5, b=7, sub=1 -> out=0xFFFFFFFFFFFFFFFE, N=1, C=0, Z=0, V=0.
- Subtract a=b=0x00000000DEADBEEF, sub=1 -> out=0, Z=1, C=1. Then add a=0x7FFFFFFFFFFFFFFF, b=1 -> out=0x8000000000000000, V=1, N=1, C=0.
- Throughput and carry propagation:
  - Stimulus: 8 back-to-back adds, a=i, b=0xFFFFFFFFFFFFFFFF, i=0..7, out_ready=1.
  - Response: 8 consecutive out_valid cycles starting at cycle 4. Results in order: 0xFFFFFFFFFFFFFFFF, then 0..6 with C=1 for i>=1. Carry must cross all chunk boundaries.
- Stall:
  - Stimulus: out_ready=0 for 3 cycles while out_valid=1.
  - Response: in_ready=0, out and flags unchanged; on release every queued op emerges in order.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously with 3 ops in flight.
  - Response: out_valid=0, busy=0, out=0 immediately; no stale result ever appears after reset.
  - Repeat the first scenario with STAGES=1 (latency 1) and STAGES=8 (latency 8).

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with LEGv8-style N/Z/C/V flags.
// The carry chain is cut into STAGES chunks, one chunk resolved per pipeline stage.
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic              adv;

    // Per-stage registers: operands travel whole, result fills in chunk by chunk.
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rc;
    logic [WIDTH-1:0]  ra [STAGES];
    logic [WIDTH-1:0]  rb [STAGES];
    logic [WIDTH-1:0]  rs [STAGES];
    logic              rz;
    logic              rv;

    // Values presented to each stage's chunk adder.
    logic [STAGES-1:0] pv;
    logic [STAGES-1:0] pc;
    logic [WIDTH-1:0]  pa [STAGES];
    logic [WIDTH-1:0]  pb [STAGES];
    logic [WIDTH-1:0]  ps [STAGES];

    logic [STAGES-1:0] nc;
    logic [WIDTH-1:0]  ns [STAGES];
    logic [CHUNK:0]    csum;

    assign adv       = !vld[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LAST];
    assign busy      = |vld;
    assign out       = rs[LAST];
    assign flag_n    = rs[LAST][WIDTH-1];
    assign flag_z    = rz;
    assign flag_c    = rc[LAST];
    assign flag_v    = rv;

    always_comb begin
        pv[0] = in_valid;
        pc[0] = sub;
        pa[0] = a;
        pb[0] = sub ? ~b : b;
        ps[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            pv[k] = vld[k-1];
            pc[k] = rc[k-1];
            pa[k] = ra[k-1];
            pb[k] = rb[k-1];
            ps[k] = rs[k-1];
        end
    end

    always_comb begin
        csum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            ns[k] = ps[k];
            csum  = {1'b0, pa[k][k*CHUNK +: CHUNK]}
                  + {1'b0, pb[k][k*CHUNK +: CHUNK]}
                  + (CHUNK+1)'(pc[k]);
            ns[k][k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            nc[k] = csum[CHUNK];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            rc  <= '0;
            rz  <= 1'b0;
            rv  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
            end
        end else if (adv) begin
            vld <= pv;
            rc  <= nc;
            for (int unsigned k = 0; k < STAGES; k++) begin
                ra[k] <= pa[k];
                rb[k] <= pb[k];
                rs[k] <= ns[k];
            end
            // Z and V need the complete result, so they are formed in the final stage.
            rz <= (ns[LAST] == '0);
            rv <= (pa[LAST][WIDTH-1] == pb[LAST][WIDTH-1]) &&
                  (ns[LAST][WIDTH-1] != pa[LAST][WIDTH-1]);
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized bench for pipelined_adder at STAGES = 4, 1 and 8 against an
// arithmetic reference model with a cycle-accurate handshake scoreboard.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic [63:0] ia   [3];
    logic [63:0] ib   [3];
    logic        isub [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic [63:0] ores [3];
    logic        fn   [3];
    logic        fz   [3];
    logic        fc   [3];
    logic        fv   [3];
    logic        bsy  [3];

    pipelined_adder #(.WIDTH(64), .STAGES(4)) u_s4 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ia[0]), .b(ib[0]), .sub(isub[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out(ores[0]), .flag_n(fn[0]), .flag_z(fz[0]), .flag_c(fc[0]), .flag_v(fv[0]),
        .busy(bsy[0])
    );

    pipelined_adder #(.WIDTH(64), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ia[1]), .b(ib[1]), .sub(isub[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out(ores[1]), .flag_n(fn[1]), .flag_z(fz[1]), .flag_c(fc[1]), .flag_v(fv[1]),
        .busy(bsy[1])
    );

    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_s8 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(ia[2]), .b(ib[2]), .sub(isub[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out(ores[2]), .flag_n(fn[2]), .flag_z(fz[2]), .flag_c(fc[2]), .flag_v(fv[2]),
        .busy(bsy[2])
    );

    typedef struct {
        logic [63:0] res;
        logic [3:0]  nzcv;
        int unsigned acc;
        int unsigned stl;
    } exp_t;

    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned stall_cnt = 0;
    int unsigned cur = 0;
    int unsigned lat [3] = '{4, 1, 8};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (STAGES=%0d, cycle %0d): got %h, expected %h",
                     tag, lat[cur], cyc, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic; C for subtraction is a >= b (no borrow).
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
        exp_t               e;
        logic [64:0]        wide;
        logic signed [65:0] ts;
        e.res = s ? a - b : a + b;
        wide  = {1'b0, a} + {1'b0, b};
        if (s) ts = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        else   ts = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        e.nzcv = {e.res[63], e.res == 64'd0, s ? (a >= b) : wide[64], ts[64] != ts[63]};
        e.acc  = 0;
        e.stl  = 0;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, check, then wait for the next one.
    // The front entry is due once STAGES cycles plus every stall cycle since acceptance have passed.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic rdy);
        logic exp_ov;
        logic adv;
        exp_t e;
        iv[cur]   = v;
        ia[cur]   = a;
        ib[cur]   = b;
        isub[cur] = s;
        ordy[cur] = rdy;
        #1;
        exp_ov = (sb.size() != 0) && (sb[0].acc + lat[cur] + (stall_cnt - sb[0].stl) <= cyc);
        adv    = !exp_ov || rdy;
        chk("out_valid", 64'(ov[cur]), 64'(exp_ov));
        chk("in_ready", 64'(ir[cur]), 64'(adv));
        chk("busy", 64'(bsy[cur]), 64'(sb.size() != 0));
        if (exp_ov) begin
            e = sb[0];
            chk("out", ores[cur], e.res);
            chk("nzcv", {60'd0, fn[cur], fz[cur], fc[cur], fv[cur]}, {60'd0, e.nzcv});
            if (rdy) void'(sb.pop_front());
        end
        if (v && adv) begin
            e     = model(a, b, s);
            e.acc = cyc;
            e.stl = stall_cnt;
            sb.push_back(e);
        end
        if (!adv) stall_cnt++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_cleared();
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 64'(ov[i]), 64'd0);
            chk("rst_busy", 64'(bsy[i]), 64'd0);
            chk("rst_out", ores[i], 64'd0);
            chk("rst_flags", {60'd0, fn[i], fz[i], fc[i], fv[i]}, 64'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic run_plan();
        step(1'b1, 64'h1234_5678_90AB_CDEF, 64'hFEDC_BA09_8765_4321, 1'b0, 1'b1);
        drain();
        step(1'b1, 64'd5, 64'd7, 1'b1, 1'b1);
        step(1'b1, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b1);
        step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        drain();
        for (int i = 0; i < 8; i++) step(1'b1, 64'(i), '1, 1'b0, 1'b1);
        drain();
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 9) < 7, rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ia[i]   = '0;
            ib[i]   = '0;
            isub[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        check_cleared();
        reset = 1'b0;

        cur = 0;
        run_plan();

        // Output held for three cycles while upstream keeps offering work.
        for (int i = 0; i < 12; i++)
            step(1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), !(i >= 4 && i <= 6));
        drain();

        run_random(300);

        for (int i = 0; i < 3; i++) step(1'b1, rnd64(), rnd64(), 1'b0, 1'b1);
        chk("busy_before_reset", 64'(bsy[cur]), 64'd1);
        #2 reset = 1'b1;
        #1 check_cleared();
        sb.delete();
        iv[cur] = 1'b0;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 64'd40, 64'd2, 1'b0, 1'b1);
        drain();

        cur = 1;
        run_plan();
        run_random(60);

        cur = 2;
        run_plan();
        run_random(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
